// File: rtl/vlsu_pkg.sv
// Shared types for the vector load path: per-beat control record, burst descriptor,
// and the burst-splitting arithmetic used by the AR issuer.
package vlsu_pkg;

  localparam int unsigned VlsuAxiDataWidth = 128;
  localparam int unsigned VlsuAxiAddrWidth = 64;
  localparam int unsigned BusBytes         = VlsuAxiDataWidth / 8;
  localparam int unsigned BusNibbles       = VlsuAxiDataWidth / 4;
  localparam int unsigned BusBSize         = $clog2(BusBytes);
  localparam int unsigned BusNSize         = $clog2(BusNibbles);
  localparam logic [1:0]  AxiBurstIncr     = 2'b01;

  typedef logic [VlsuAxiAddrWidth-1:0] addr_t;
  typedef logic [VlsuAxiAddrWidth:0]   wide_t;

  typedef enum logic {S_IDLE, S_ISSUE} issue_state_e;

  typedef struct packed {
    addr_t             addr;
    logic              isHead;
    logic [7:0]        rmnBeat;
    logic [BusNSize:0] lbN;
    logic              isFinalTxn;
  } txn_ctrl_t;

  typedef struct packed {
    addr_t             addr;
    logic [7:0]        len;
    logic [BusNSize:0] lbN;
    logic              isFinalTxn;
  } txn_desc_t;

  typedef struct packed {
    addr_t             last;
    logic [7:0]        len;
    logic [BusNSize:0] lbN;
    logic              is_final;
  } txn_calc_t;

  // One extra bit keeps the 4 KiB / burst limits from wrapping at the top of memory.
  function automatic txn_calc_t calc_txn(input addr_t cur_addr, input addr_t end_addr,
                                         input int unsigned max_burst_len);
    wide_t             cur, fin, lim4k, lim_burst, last, beats;
    logic [BusBSize:0] last_bytes;
    txn_calc_t         res;
    cur       = {1'b0, cur_addr};
    fin       = {1'b0, end_addr};
    lim4k     = cur | wide_t'(12'hFFF);
    lim_burst = ((cur >> BusBSize) << BusBSize) + wide_t'(max_burst_len * BusBytes) - wide_t'(1);
    last      = fin;
    if (lim4k < last) last = lim4k;
    if (lim_burst < last) last = lim_burst;
    beats        = (last >> BusBSize) - (cur >> BusBSize) + wide_t'(1);
    last_bytes   = {1'b0, last[BusBSize-1:0]} + (BusBSize+1)'(1);
    res.last     = last[VlsuAxiAddrWidth-1:0];
    res.len      = 8'(beats - wide_t'(1));
    res.lbN      = {last_bytes, 1'b0};
    res.is_final = (last == fin);
    return res;
  endfunction

endpackage

// File: rtl/QueueFlow.sv
// Small register FIFO with optional fall-through from input to output when empty.
module QueueFlow #(
  parameter type         T            = logic,
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  T                mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0] cnt_reg;
  logic            stored_empty, bypass, do_push, do_pop;

  assign stored_empty = (cnt_reg == '0);
  assign full_o       = (cnt_reg == CntW'(DEPTH));

  if (FALL_THROUGH) begin : g_ft
    assign bypass = stored_empty && push_i;
  end else begin : g_no_ft
    assign bypass = 1'b0;
  end

  assign empty_o = stored_empty && !bypass;
  assign data_o  = bypass ? data_i : mem[rd_ptr_reg];
  // A bypassed entry consumed in the same cycle is never stored.
  assign do_push = push_i && !full_o && !(bypass && pop_i);
  assign do_pop  = pop_i && !stored_empty;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PtrW'(1);
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + CntW'(1);
        2'b01:   cnt_reg <= cnt_reg - CntW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/vseq_load_txn_gen.sv
// Splits one contiguous vector-load request into 4 KiB-safe AXI INCR bursts and
// emits one txn_ctrl record per expected R beat, in AR order.
module vseq_load_txn_gen
  import vlsu_pkg::*;
#(
  parameter int unsigned AxiDataWidth  = VlsuAxiDataWidth,
  parameter int unsigned AxiAddrWidth  = VlsuAxiAddrWidth,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned MaxBurstLen   = 256,
  parameter int unsigned TxnQueueDepth = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]     req_nbytes_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic                    txn_ctrl_valid_o,
  input  logic                    txn_ctrl_ready_i,
  output txn_ctrl_t               txn_ctrl_o
);

  localparam int unsigned ArSize = $clog2(AxiDataWidth / 8);

  issue_state_e state_reg;
  addr_t        cur_addr_reg, end_addr_reg;
  logic [7:0]   beat_cnt_reg;
  txn_calc_t    calc;
  txn_desc_t    push_desc, head_desc;
  logic         desc_full, desc_empty, ar_fire, ctrl_fire, desc_pop;
  logic [7:0]   rmn_beat;

  assign calc    = calc_txn(cur_addr_reg, end_addr_reg, MaxBurstLen);
  assign ar_fire = ar_valid_o && ar_ready_i;

  assign req_ready_o = (state_reg == S_IDLE);
  assign ar_valid_o  = (state_reg == S_ISSUE) && !desc_full;
  assign ar_addr_o   = (state_reg == S_ISSUE) ? cur_addr_reg : '0;
  assign ar_len_o    = (state_reg == S_ISSUE) ? calc.len : '0;
  assign ar_size_o   = 3'(ArSize);
  assign ar_burst_o  = AxiBurstIncr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= S_IDLE;
      cur_addr_reg <= '0;
      end_addr_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (req_valid_i) begin
          cur_addr_reg <= req_addr_i;
          end_addr_reg <= req_addr_i + addr_t'(req_nbytes_i) - addr_t'(1);
          state_reg    <= S_ISSUE;
        end
        S_ISSUE: if (ar_fire) begin
          cur_addr_reg <= calc.last + addr_t'(1);
          if (calc.is_final) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    push_desc            = '0;
    push_desc.addr       = cur_addr_reg;
    push_desc.len        = calc.len;
    push_desc.lbN        = calc.lbN;
    push_desc.isFinalTxn = calc.is_final;
  end

  // No fall-through: a descriptor becomes visible the cycle after its AR handshake.
  QueueFlow #(
    .T            (txn_desc_t),
    .DEPTH        (TxnQueueDepth),
    .FALL_THROUGH (1'b0)
  ) u_desc_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ar_fire),
    .data_i  (push_desc),
    .pop_i   (desc_pop),
    .data_o  (head_desc),
    .full_o  (desc_full),
    .empty_o (desc_empty)
  );

  assign txn_ctrl_valid_o = !desc_empty;
  assign rmn_beat         = head_desc.len - beat_cnt_reg;
  assign ctrl_fire        = txn_ctrl_valid_o && txn_ctrl_ready_i;
  assign desc_pop         = ctrl_fire && (rmn_beat == 8'd0);

  always_comb begin
    txn_ctrl_o = '0;
    if (!desc_empty) begin
      txn_ctrl_o.addr       = head_desc.addr;
      txn_ctrl_o.isHead     = (beat_cnt_reg == 8'd0);
      txn_ctrl_o.rmnBeat    = rmn_beat;
      txn_ctrl_o.lbN        = head_desc.lbN;
      txn_ctrl_o.isFinalTxn = head_desc.isFinalTxn;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_reg <= '0;
    end else if (desc_pop) begin
      beat_cnt_reg <= '0;
    end else if (ctrl_fire) begin
      beat_cnt_reg <= beat_cnt_reg + 8'd1;
    end
  end

  a_nbytes_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_valid_i && req_ready_o) |-> (req_nbytes_i != '0));

endmodule

// File: tb/tb_vseq_load_txn_gen.sv
// Scoreboard bench: expected AR bursts and beat records are queued when a request is
// driven and compared as the DUT hands them over.
module tb_vseq_load_txn_gen;
  import vlsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [63:0] req_addr_i;
  logic [31:0] req_nbytes_i;
  logic        ar_valid_o, ar_ready_i;
  logic [63:0] ar_addr_o;
  logic [7:0]  ar_len_o;
  logic [2:0]  ar_size_o;
  logic [1:0]  ar_burst_o;
  logic        txn_ctrl_valid_o, txn_ctrl_ready_i;
  txn_ctrl_t   txn_ctrl_o;

  vseq_load_txn_gen dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_nbytes_i(req_nbytes_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .txn_ctrl_valid_o(txn_ctrl_valid_o), .txn_ctrl_ready_i(txn_ctrl_ready_i),
    .txn_ctrl_o(txn_ctrl_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_exp_t;

  int        checks = 0;
  int        failures = 0;
  ar_exp_t   exp_ar[$];
  txn_ctrl_t exp_beat[$];
  ar_exp_t   ar_e;
  txn_ctrl_t beat_e;
  int        ar_hs, beat_hs, final_last_cnt;
  logic      samp_ar_valid, samp_txn_valid, samp_pop, accepted;
  txn_ctrl_t first_rec, last_rec;
  logic [63:0] first_ar_addr;
  logic [7:0]  first_ar_len;

  // Independent reference split: walk the request byte range burst by burst.
  task automatic start_req(input logic [63:0] addr, input logic [31:0] nbytes);
    longint unsigned cur, fin, lim4k, limb, t, nb;
    txn_ctrl_t r;
    ar_exp_t   a;
    cur = addr;
    fin = addr + nbytes - 1;
    do begin
      lim4k = cur | 64'hFFF;
      limb  = (cur / 16) * 16 + 4096 - 1;
      t = fin;
      if (lim4k < t) t = lim4k;
      if (limb < t) t = limb;
      nb = t / 16 - cur / 16 + 1;
      a.addr = cur;
      a.len  = 8'(nb - 1);
      exp_ar.push_back(a);
      for (longint unsigned b = 0; b < nb; b++) begin
        r.addr       = cur;
        r.isHead     = (b == 0);
        r.rmnBeat    = 8'(nb - 1 - b);
        r.lbN        = 6'(2 * ((t % 16) + 1));
        r.isFinalTxn = (t == fin);
        exp_beat.push_back(r);
      end
      cur = t + 1;
    end while (t != fin);
    ar_hs = 0; beat_hs = 0; final_last_cnt = 0;
    req_addr_i = addr; req_nbytes_i = nbytes; req_valid_i = 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk_i);
    samp_ar_valid  = ar_valid_o;
    samp_txn_valid = txn_ctrl_valid_o;
    samp_pop       = 1'b0;
    accepted       = req_valid_i && req_ready_o;
    if (ar_valid_o && ar_ready_i) begin
      checks++;
      if (exp_ar.size() == 0) begin
        failures++;
        $display("FAIL ar_unexpected got addr=%h len=%0d required none", ar_addr_o, ar_len_o);
      end else begin
        ar_e = exp_ar.pop_front();
        if (ar_addr_o !== ar_e.addr || ar_len_o !== ar_e.len || ar_size_o !== 3'd4 || ar_burst_o !== 2'b01) begin
          failures++;
          $display("FAIL ar_burst got addr=%h len=%0d size=%0d burst=%0d required addr=%h len=%0d size=4 burst=1",
                   ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_e.addr, ar_e.len);
        end
      end
      if (ar_hs == 0) begin first_ar_addr = ar_addr_o; first_ar_len = ar_len_o; end
      $display("AR   #%0d addr=%h len=%0d", ar_hs, ar_addr_o, ar_len_o);
      ar_hs++;
    end
    if (txn_ctrl_valid_o && txn_ctrl_ready_i) begin
      checks++;
      if (exp_beat.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got %h required none", txn_ctrl_o);
      end else begin
        beat_e = exp_beat.pop_front();
        if (txn_ctrl_o !== beat_e) begin
          failures++;
          $display("FAIL beat_record got addr=%h head=%0d rmn=%0d lbN=%0d fin=%0d required addr=%h head=%0d rmn=%0d lbN=%0d fin=%0d",
                   txn_ctrl_o.addr, txn_ctrl_o.isHead, txn_ctrl_o.rmnBeat, txn_ctrl_o.lbN, txn_ctrl_o.isFinalTxn,
                   beat_e.addr, beat_e.isHead, beat_e.rmnBeat, beat_e.lbN, beat_e.isFinalTxn);
        end
      end
      if (beat_hs == 0) first_rec = txn_ctrl_o;
      last_rec = txn_ctrl_o;
      if (txn_ctrl_o.isFinalTxn && txn_ctrl_o.rmnBeat == 8'd0) final_last_cnt++;
      if (txn_ctrl_o.rmnBeat == 8'd0) samp_pop = 1'b1;
      beat_hs++;
    end
    @(posedge clk_i);
    #1;
    if (accepted) req_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_ar.size() != 0 || exp_beat.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_ar.size() != 0 || exp_beat.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got pending ar=%0d beats=%0d required 0", name, exp_ar.size(), exp_beat.size());
      exp_ar.delete(); exp_beat.delete();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_nbytes_i = '0;
    ar_ready_i = 1'b0; txn_ctrl_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || ar_valid_o !== 1'b0 || txn_ctrl_valid_o !== 1'b0 ||
        ar_addr_o !== 64'd0 || ar_len_o !== 8'd0 || txn_ctrl_o !== '0) begin
      failures++;
      $display("FAIL reset_state got rdy=%0d arv=%0d tv=%0d addr=%h len=%0d ctrl=%h required 1 0 0 0 0 0",
               req_ready_o, ar_valid_o, txn_ctrl_valid_o, ar_addr_o, ar_len_o, txn_ctrl_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_aligned();
    ar_ready_i = 1'b1; txn_ctrl_ready_i = 1'b1;
    start_req(64'h1000, 32'd64);
    cycle();
    checks++;
    if (accepted !== 1'b1) begin failures++; $display("FAIL aligned_accept got %0d required 1", accepted); end
    cycle();
    checks++;
    if (samp_ar_valid !== 1'b1) begin failures++; $display("FAIL aligned_ar_latency got %0d required 1", samp_ar_valid); end
    checks++;
    if (samp_txn_valid !== 1'b0) begin failures++; $display("FAIL aligned_no_fallthrough got %0d required 0", samp_txn_valid); end
    drain(50, "aligned");
    checks++;
    if (beat_hs != 4 || last_rec.lbN !== 6'd32 || first_ar_len !== 8'd3) begin
      failures++;
      $display("FAIL aligned_shape got beats=%0d lbN=%0d len=%0d required 4 32 3", beat_hs, last_rec.lbN, first_ar_len);
    end
  endtask

  task automatic test_unaligned();
    start_req(64'h1003, 32'd20);
    drain(50, "unaligned");
    checks++;
    if (first_ar_addr !== 64'h1003 || first_ar_len !== 8'd1 || last_rec.lbN !== 6'd14) begin
      failures++;
      $display("FAIL unaligned_burst got addr=%h len=%0d lbN=%0d required 1003 1 14", first_ar_addr, first_ar_len, last_rec.lbN);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin failures++; $display("FAIL unaligned_ready got %0d required 1", req_ready_o); end
  endtask

  task automatic test_4k_cross();
    start_req(64'h0FF8, 32'd16);
    drain(50, "cross4k");
    checks++;
    if (ar_hs != 2 || first_rec.lbN !== 6'd32 || first_rec.isFinalTxn !== 1'b0 ||
        last_rec.addr !== 64'h1000 || last_rec.lbN !== 6'd16) begin
      failures++;
      $display("FAIL cross4k_split got ars=%0d lbN0=%0d fin0=%0d addr1=%h lbN1=%0d required 2 32 0 1000 16",
               ar_hs, first_rec.lbN, first_rec.isFinalTxn, last_rec.addr, last_rec.lbN);
    end
  endtask

  task automatic test_two_burst();
    start_req(64'h0, 32'd8192);
    drain(700, "two_burst");
    checks++;
    if (ar_hs != 2 || beat_hs != 512 || final_last_cnt != 1) begin
      failures++;
      $display("FAIL two_burst_count got ars=%0d beats=%0d finals=%0d required 2 512 1", ar_hs, beat_hs, final_last_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int ar_pre;
    logic prev_pop = 1'b0;
    ar_ready_i = 1'b1; txn_ctrl_ready_i = 1'b0;
    start_req(64'h0, 32'd24576);
    repeat (12) cycle();
    checks++;
    if (ar_hs != 4 || samp_ar_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall got ars=%0d arv=%0d required 4 0", ar_hs, samp_ar_valid);
    end
    txn_ctrl_ready_i = 1'b1;
    while ((exp_ar.size() != 0 || exp_beat.size() != 0) && n < 3000) begin
      ar_pre = ar_hs;
      cycle();
      n++;
      if (prev_pop && ar_pre < 6) begin
        checks++;
        if (samp_ar_valid !== 1'b1) begin failures++; $display("FAIL bp_resume got arv=%0d required 1", samp_ar_valid); end
      end
      if (samp_pop && ar_pre < 6) begin
        checks++;
        if (samp_ar_valid !== 1'b0) begin failures++; $display("FAIL bp_no_bypass got arv=%0d required 0", samp_ar_valid); end
      end
      prev_pop = samp_pop;
    end
    checks++;
    if (exp_ar.size() != 0 || exp_beat.size() != 0 || ar_hs != 6) begin
      failures++;
      $display("FAIL bp_timeout got ars=%0d pending=%0d required 6 0", ar_hs, exp_beat.size());
      exp_ar.delete(); exp_beat.delete();
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    ar_ready_i = 1'b1; txn_ctrl_ready_i = 1'b1;
    start_req(64'h0, 32'd16384);
    while (ar_hs < 2 && n < 20) begin cycle(); n++; end
    checks++;
    if (ar_hs != 2) begin failures++; $display("FAIL rstmid_pre got ars=%0d required 2", ar_hs); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (ar_valid_o !== 1'b0 || txn_ctrl_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_outputs got arv=%0d tv=%0d rdy=%0d required 0 0 1", ar_valid_o, txn_ctrl_valid_o, req_ready_o);
    end
    exp_ar.delete(); exp_beat.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    start_req(64'h2040, 32'd32);
    drain(50, "rstmid_fresh");
    checks++;
    if (first_ar_addr !== 64'h2040 || first_rec.isHead !== 1'b1 || first_rec.rmnBeat !== 8'd1) begin
      failures++;
      $display("FAIL rstmid_fresh got addr=%h head=%0d rmn=%0d required 2040 1 1", first_ar_addr, first_rec.isHead, first_rec.rmnBeat);
    end
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog got no finish required finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_4k_cross();
    test_two_burst();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
